// File: rtl/csa_pipe_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and helpers for the pipelined carry-select
//               adder/subtractor: flag bit positions, packed flag struct
//               and the signed saturation constant generator.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_OVF   = 1;

    // Widest datapath the saturation helper can produce a constant for.
    localparam int SAT_MAX_W = 64;
    localparam logic [SAT_MAX_W-1:0] SAT_ONE = {{(SAT_MAX_W-1){1'b0}}, 1'b1};

    // Bit 1 = signed overflow, bit 0 = carry out (carry = 1 means no borrow).
    typedef struct packed {
        logic ovf;
        logic carry;
    } alu_flags_t;

    // Saturation value for a width-bit signed result: most negative value when
    // the sign operand is negative, most positive value otherwise. Callers
    // truncate the result to their own width.
    function automatic logic [SAT_MAX_W-1:0] sat_value(input logic sign, input int width);
        logic [SAT_MAX_W-1:0] msb_only;
        msb_only = SAT_ONE << (width - 1);
        return sign ? msb_only : (msb_only - SAT_ONE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_pipe_addsub_seg.sv
`default_nettype none
// ============================================================================
// Module      : csa_seg
// Description : Combinational carry-select segment. Every BLK-bit block
//               computes its sum for carry-in 0 and 1; the carry rippling
//               in from the previous block picks one result.
// Ports       : a, b      segment operand bits (b already inverted for sub)
//               cin       carry into the segment LSB
//               sum       segment sum bits
//               cout      carry out of the segment MSB
//               c_msb_in  carry into the segment MSB (overflow detection)
// Revision    : 1.0 - initial release
// ============================================================================
module csa_seg #(
    parameter int SEG_W = 16,
    parameter int BLK   = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    localparam int NBLK = SEG_W / BLK;
    localparam logic [BLK:0] BLK_ONE = {{BLK{1'b0}}, 1'b1};

    logic [NBLK:0] carry;

    assign carry[0] = cin;

    for (genvar j = 0; j < NBLK; j++) begin : g_blk
        logic [BLK:0] sum_c0;
        logic [BLK:0] sum_c1;

        assign sum_c0 = {1'b0, a[j*BLK +: BLK]} + {1'b0, b[j*BLK +: BLK]};
        assign sum_c1 = {1'b0, a[j*BLK +: BLK]} + {1'b0, b[j*BLK +: BLK]} + BLK_ONE;

        assign sum[j*BLK +: BLK] = carry[j] ? sum_c1[BLK-1:0] : sum_c0[BLK-1:0];
        assign carry[j+1]        = carry[j] ? sum_c1[BLK]     : sum_c0[BLK];
    end

    assign cout = carry[NBLK];
    // The carry entering a bit position equals a ^ b ^ sum at that position.
    assign c_msb_in = a[SEG_W-1] ^ b[SEG_W-1] ^ sum[SEG_W-1];

endmodule
`default_nettype wire

// File: rtl/csa_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : csa_pipe_addsub
// Description : Pipelined carry-select adder/subtractor. The WIDTH-bit
//               operation is cut into STAGES segments; each segment adds its
//               slice and registers the carry, the finished low sum bits and
//               the still-unprocessed high operand bits. One op in / one op
//               out per cycle, global stall on output backpressure.
//               Optional signed saturation: define CSA_SAT_EN.
// Ports       : clk, rst_n                 clock, async active-low reset
//               in_valid/in_ready          operand handshake
//               in_a, in_b, in_cin, in_sub operands and operation select
//               out_valid/out_ready        result handshake
//               out_sum, out_flags         result and {overflow, carry}
// Revision    : 1.0 - initial release
// ============================================================================
module csa_pipe_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BLK    = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [1:0]       out_flags
);

    localparam int SEG = WIDTH / STAGES;

    if ((WIDTH % (STAGES * BLK)) != 0) begin : g_cfg_err_div
        $error("csa_pipe_addsub: WIDTH must be a multiple of STAGES*BLK");
    end
    if ((STAGES < 1) || (STAGES > (WIDTH / BLK))) begin : g_cfg_err_stages
        $error("csa_pipe_addsub: STAGES must be within 1..WIDTH/BLK");
    end
`ifdef CSA_SAT_EN
    if (WIDTH > SAT_MAX_W) begin : g_cfg_err_sat
        $error("csa_pipe_addsub: saturation supports WIDTH up to SAT_MAX_W");
    end
`endif

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    alu_flags_t       flags_q, flags_d;
    logic             advance;

    // Results leaving the last segment, before the output register.
    logic             last_v;
    logic [WIDTH-1:0] last_sum;
    logic             last_carry;
    logic             last_ovf;
`ifdef CSA_SAT_EN
    logic             last_sign;
`endif

    // Whole pipeline moves in lockstep; a stalled output freezes every stage.
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG;
        localparam int HI = LO + SEG;

        logic [WIDTH-1:LO] src_a;
        logic [WIDTH-1:LO] src_b;
        logic              src_c;
        logic              src_v;
        logic [HI-1:0]     acc;
        logic [SEG-1:0]    seg_sum;
        logic              seg_cout;
        logic              seg_cmsb;

        csa_seg #(
            .SEG_W (SEG),
            .BLK   (BLK)
        ) u_seg (
            .a        (src_a[HI-1:LO]),
            .b        (src_b[HI-1:LO]),
            .cin      (src_c),
            .sum      (seg_sum),
            .cout     (seg_cout),
            .c_msb_in (seg_cmsb)
        );

        if (k == 0) begin : g_src
            // Subtraction is A + ~B + 1, so the carry-in is forced high.
            assign src_a = in_a;
            assign src_b = in_sub ? ~in_b : in_b;
            assign src_c = in_sub | in_cin;
            assign src_v = in_valid;
            assign acc   = seg_sum;
        end else begin : g_src
            assign src_a = g_stage[k-1].g_reg.a_q;
            assign src_b = g_stage[k-1].g_reg.b_q;
            assign src_c = g_stage[k-1].g_reg.carry_q;
            assign src_v = g_stage[k-1].g_reg.valid_q;
            assign acc   = {seg_sum, g_stage[k-1].g_reg.sum_q};
        end

        if (k < STAGES - 1) begin : g_reg
            logic [WIDTH-1:HI] a_q, a_d;
            logic [WIDTH-1:HI] b_q, b_d;
            logic [HI-1:0]     sum_q, sum_d;
            logic              carry_q, carry_d;
            logic              valid_q, valid_d;
            logic              cmsb_unused;

            // Only the top segment needs the MSB carry-in.
            assign cmsb_unused = seg_cmsb;

            always_comb begin
                a_d     = a_q;
                b_d     = b_q;
                sum_d   = sum_q;
                carry_d = carry_q;
                valid_d = valid_q;
                if (advance) begin
                    a_d     = src_a[WIDTH-1:HI];
                    b_d     = src_b[WIDTH-1:HI];
                    sum_d   = acc;
                    carry_d = seg_cout;
                    valid_d = src_v;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q     <= '0;
                    b_q     <= '0;
                    sum_q   <= '0;
                    carry_q <= 1'b0;
                    valid_q <= 1'b0;
                end else begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    valid_q <= valid_d;
                end
            end
        end else begin : g_last
            assign last_v     = src_v;
            assign last_sum   = acc;
            assign last_carry = seg_cout;
            assign last_ovf   = seg_cout ^ seg_cmsb;
`ifdef CSA_SAT_EN
            assign last_sign  = src_a[WIDTH-1];
`endif
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        flags_d     = flags_q;
        if (advance) begin
            out_valid_d   = last_v;
            flags_d.ovf   = last_ovf;
            flags_d.carry = last_carry;
`ifdef CSA_SAT_EN
            // Flags keep the raw result; only the sum is clamped.
            out_sum_d     = last_ovf ? WIDTH'(sat_value(last_sign, WIDTH)) : last_sum;
`else
            out_sum_d     = last_sum;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            flags_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_flags = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_csa_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_csa_pipe_addsub
// Description : Directed bench for csa_pipe_addsub (8-bit/2-stage instance)
//               plus a randomised backpressure run on a 32-bit/4-stage
//               instance against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_pipe_addsub;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 8-bit, 2-stage instance
    logic       in_valid, in_ready, in_cin, in_sub, out_valid, out_ready;
    logic [7:0] in_a, in_b, out_sum;
    logic [1:0] out_flags;

    // 32-bit, 4-stage instance
    logic        b_in_valid, b_in_ready, b_in_cin, b_in_sub, b_out_valid, b_out_ready;
    logic [31:0] b_in_a, b_in_b, b_out_sum;
    logic [1:0]  b_out_flags;

    int checks = 0;
    int failures = 0;

    csa_pipe_addsub #(.WIDTH(8), .BLK(4), .STAGES(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_flags(out_flags)
    );

    csa_pipe_addsub #(.WIDTH(32), .BLK(4), .STAGES(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_a(b_in_a), .in_b(b_in_b), .in_cin(b_in_cin), .in_sub(b_in_sub),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_flags(b_out_flags)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: returns {ovf, carry, sum[63:0]} for a w-bit operation.
    function automatic logic [65:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                           input logic cin, input logic sub, input int w);
        logic [64:0] mask, full;
        logic [63:0] am, bb, s;
        logic        c0, carry, ovf;
        mask  = (65'd1 << w) - 65'd1;
        am    = a & mask[63:0];
        bb    = (sub ? ~b : b) & mask[63:0];
        c0    = sub ? 1'b1 : cin;
        full  = {1'b0, am} + {1'b0, bb} + {64'd0, c0};
        carry = full[w];
        s     = full[63:0] & mask[63:0];
        ovf   = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
`ifdef CSA_SAT_EN
        if (ovf) s = am[w-1] ? (64'd1 << (w-1)) : ((64'd1 << (w-1)) - 64'd1);
`endif
        return {ovf, carry, s};
    endfunction

    function automatic logic [9:0] exp8(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin, input logic sub);
        logic [65:0] r;
        r = ref_op({56'd0, a}, {56'd0, b}, cin, sub, 8);
        return {r[65:64], r[7:0]};
    endfunction

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    endtask

    // One isolated op: must be absent after one edge and present after two.
    task automatic single(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub, input logic [9:0] exp);
        drive8(a, b, cin, sub);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        chk(tag, {53'd0, out_valid, out_flags, out_sum}, {53'd0, 1'b1, exp});
    endtask

    logic [7:0] sa [16];
    logic [7:0] sb [16];
    logic       sc [16];
    logic       ss [16];
    logic [65:0] sbq [$];
    logic [65:0] e;
    int seen, pushed, cyc;

    initial begin
        in_valid = 0; in_a = 0; in_b = 0; in_cin = 0; in_sub = 0; out_ready = 1;
        b_in_valid = 0; b_in_a = 0; b_in_b = 0; b_in_cin = 0; b_in_sub = 0; b_out_ready = 1;

        // Reset state
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {54'd0, out_flags, out_sum}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_b_out_valid", {63'd0, b_out_valid}, 64'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // Arithmetic corners
`ifdef CSA_SAT_EN
        single("t1_add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, {2'b10, 8'h7F});
        single("t2_sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, {2'b11, 8'h80});
        single("t2_add_neg_ovf", 8'h80, 8'h80, 1'b0, 1'b0, {2'b11, 8'h80});
`else
        single("t1_add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, {2'b10, 8'h80});
        single("t2_sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, {2'b11, 8'h7F});
        single("t2_add_neg_ovf", 8'h80, 8'h80, 1'b0, 1'b0, {2'b11, 8'h00});
`endif
        single("t2_sub_borrow", 8'h00, 8'h01, 1'b0, 1'b1, {2'b00, 8'hFF});
        single("t2_add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, {2'b01, 8'h00});
        single("t2_add_cin", 8'h10, 8'h20, 1'b1, 1'b0, {2'b00, 8'h31});
        single("t2_sub_cin_ignored", 8'h05, 8'h03, 1'b1, 1'b1, {2'b01, 8'h02});
        single("t2_seg_carry", 8'h0F, 8'h01, 1'b0, 1'b0, {2'b00, 8'h10});

        // Back-to-back stream of 16 ops
        for (int i = 0; i < 16; i++) begin
            sa[i] = 8'(i * 37 + 5);
            sb[i] = 8'(i * 91 + 13);
            sc[i] = i[1];
            ss[i] = i[0];
        end
        drive8(sa[0], sb[0], sc[0], ss[0]);
        for (int k = 0; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k == 0)
                chk("t3_first_lat", {63'd0, out_valid}, 64'd0);
            else
                chk($sformatf("t3_res%0d", k - 1), {53'd0, out_valid, out_flags, out_sum},
                    {53'd0, 1'b1, exp8(sa[k-1], sb[k-1], sc[k-1], ss[k-1])});
            if (k + 1 < 16) drive8(sa[k+1], sb[k+1], sc[k+1], ss[k+1]);
            else in_valid = 1'b0;
        end
        @(posedge clk); #1;
        chk("t3_drain", {63'd0, out_valid}, 64'd0);

        // Backpressure with a full pipeline
        drive8(8'h11, 8'h22, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive8(8'h40, 8'h50, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("t4_p0", {53'd0, out_valid, out_flags, out_sum}, {53'd0, 1'b1, exp8(8'h11, 8'h22, 1'b0, 1'b0)});
        out_ready = 1'b0;
        drive8(8'h7F, 8'h7F, 1'b0, 1'b0);
        #1;
        chk("t4_in_ready_low", {63'd0, in_ready}, 64'd0);
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            chk($sformatf("t4_hold%0d", s), {53'd0, out_valid, out_flags, out_sum},
                {53'd0, 1'b1, exp8(8'h11, 8'h22, 1'b0, 1'b0)});
            chk($sformatf("t4_stall_ready%0d", s), {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t4_p1", {53'd0, out_valid, out_flags, out_sum}, {53'd0, 1'b1, exp8(8'h40, 8'h50, 1'b0, 1'b1)});
        @(posedge clk); #1;
        chk("t4_p2", {53'd0, out_valid, out_flags, out_sum}, {53'd0, 1'b1, exp8(8'h7F, 8'h7F, 1'b0, 1'b0)});
        @(posedge clk); #1;
        chk("t4_empty", {63'd0, out_valid}, 64'd0);

        // Asynchronous reset with two ops in flight
        drive8(8'h12, 8'h34, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive8(8'h55, 8'h66, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t5_q0", {53'd0, out_valid, out_flags, out_sum}, {53'd0, 1'b1, exp8(8'h12, 8'h34, 1'b0, 1'b0)});
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_async_data", {54'd0, out_flags, out_sum}, 64'd0);
        chk("t5_rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t5_no_stale", {63'd0, out_valid}, 64'd0);
        single("t5_after", 8'h21, 8'h0E, 1'b0, 1'b1, {2'b01, 8'h13});

        // 32-bit, 4-stage random run with backpressure
        seen = 0; pushed = 0; cyc = 0;
        while (seen < 600 && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            b_in_valid  = (pushed < 600) && ($urandom_range(0, 3) != 0);
            b_in_a      = $urandom;
            b_in_b      = $urandom;
            b_in_cin    = 1'($urandom_range(0, 1));
            b_in_sub    = 1'($urandom_range(0, 1));
            b_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (b_out_valid && b_out_ready) begin
                chk("t6_has_expect", {63'd0, sbq.size() > 0}, 64'd1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk($sformatf("t6_res%0d", seen), {30'd0, b_out_flags, b_out_sum},
                        {30'd0, e[65:64], e[31:0]});
                end
                seen++;
            end
            if (b_in_valid && b_in_ready) begin
                sbq.push_back(ref_op({32'd0, b_in_a}, {32'd0, b_in_b}, b_in_cin, b_in_sub, 32));
                pushed++;
            end
        end
        b_in_valid = 1'b0;
        chk("t6_count", 64'(seen), 64'd600);
        chk("t6_drained", 64'(sbq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
